// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencing stage: req/ack fetch into an instruction register,
// compact decode for the controller, next-PC selection. Optional: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            jal,
    input  logic            jalr,
    input  logic            branch,
    input  logic            zero,
    input  logic            neg,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic            instr_valid,
    output logic            halted,
    output logic [1:0]      trap_cause,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [1:0]      trap_q, trap_d;

    logic [XLEN-1:0] next_pc;
    logic            br_taken;
    logic            rdata_legal;

    always_comb begin
        rdata_legal = 1'b0;
        case (imem_rdata[6:0])
            OPC_R, OPC_IMM, OPC_LOAD, OPC_JALR,
            OPC_S, OPC_B, OPC_LUI, OPC_JAL: rdata_legal = 1'b1;
            default:                        rdata_legal = 1'b0;
        endcase
    end

    // Compact type code plus the func3 remap the controller expects for LOAD/JALR.
    always_comb begin
        op    = 7'd0;
        func3 = instr_q[14:12];
        func7 = instr_q[31:25];
        case (instr_q[6:0])
            OPC_R:    op = 7'd0;
            OPC_IMM:  op = 7'd1;
            OPC_LOAD: begin
                op    = 7'd1;
                func3 = 3'b110;
            end
            OPC_JALR: begin
                op    = 7'd1;
                func3 = 3'b111;
            end
            OPC_S:    op = 7'd2;
            OPC_B:    op = 7'd3;
            OPC_LUI:  op = 7'd4;
            OPC_JAL:  op = 7'd5;
            default:  op = 7'd0;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        if (branch) begin
            case (instr_q[14:12])
                3'b000:  br_taken = zero;
                3'b001:  br_taken = !zero;
                3'b100:  br_taken = neg;
                3'b101:  br_taken = !neg;
                default: br_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (jalr)
            next_pc = alu_result & ~XLEN'(1);
        else if (jal || br_taken)
            next_pc = pc_q + imm;
        else
            next_pc = pc_q + FOUR;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        trap_d  = trap_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    if (rdata_legal) begin
                        state_d = EXEC;
                    end else begin
                        state_d = HALT;
                        trap_d  = 2'b01;
                    end
                end
            end
            EXEC: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (next_pc[1:0] != 2'b00) begin
                    state_d = HALT;
                    trap_d  = 2'b10;
                end else begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
`else
                pc_d    = {next_pc[XLEN-1:2], 2'b00};
                state_d = FETCH;
`endif
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            trap_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            trap_q  <= trap_d;
        end
    end

    // HALT is absorbing, so decoding it directly gives a sticky flag.
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALT);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + FOUR;
    assign instr       = instr_q;
    assign trap_cause  = trap_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: fetch sequencing, wait states, branches,
// jumps, decode remap, illegal-opcode halt and asynchronous reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        jal, jalr, branch, zero, neg;
    logic [31:0] pc, pc_plus4, instr;
    logic [6:0]  op;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        instr_valid, halted;
    logic [1:0]  trap_cause;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] ADDI = 32'h0010_0093;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .imm(imm), .alu_result(alu_result),
        .jal(jal), .jalr(jalr), .branch(branch), .zero(zero), .neg(neg),
        .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
        .op(op), .func3(func3), .func7(func7),
        .instr_valid(instr_valid), .halted(halted), .trap_cause(trap_cause),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        jal = 0; jalr = 0; branch = 0; zero = 0; neg = 0;
        imm = '0; alu_result = '0;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_ack = 1'b0;
        clear_ctrl();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    // Waits (bounded) for a request, inserts wait cycles, then acks with word.
    task automatic do_fetch(input logic [31:0] word, input int waits);
        int t = 0;
        while (!imem_req && t < 8) begin
            step();
            t++;
        end
        if (!imem_req) begin
            n_vec++; n_err++;
            $display("FAIL fetch_wait: imem_req=%0b required 1", imem_req);
        end
        imem_rdata = word;
        imem_ack   = 1'b0;
        repeat (waits) step();
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        clear_ctrl();
    endtask

    task automatic exec_step(input logic j, input logic jr, input logic br, input logic z,
                             input logic n, input logic [31:0] immv, input logic [31:0] alu);
        jal = j; jalr = jr; branch = br; zero = z; neg = n; imm = immv; alu_result = alu;
        step();
        clear_ctrl();
    endtask

    task automatic test_reset();
        hold_reset();
        n_vec++;
        if ({pc, instr, op, func3, func7} !== {32'h0, 32'h0000_0013, 7'd1, 3'b000, 7'd0}) begin
            n_err++;
            $display("FAIL reset_regs: pc=%h instr=%h op=%0d f3=%b f7=%h required 0/00000013/1/000/00",
                     pc, instr, op, func3, func7);
        end
        n_vec++;
        if ({imem_req, instr_valid, halted, trap_cause} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: req=%b valid=%b halted=%b trap=%b required all 0",
                     imem_req, instr_valid, halted, trap_cause);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL idle_no_req: imem_req=%b required 0", imem_req);
        end
        step();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h required 1/00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 2; i++) begin
            do_fetch(ADDI, 0);
            n_vec++;
            if (instr_valid !== 1'b1 || op !== 7'd1 || func3 !== 3'b000 || pc !== 32'(i * 4)) begin
                n_err++;
                $display("FAIL seq_exec%0d: valid=%b op=%0d f3=%b pc=%h required 1/1/000/%h",
                         i, instr_valid, op, func3, pc, 32'(i * 4));
            end
            exec_step(0, 0, 0, 0, 0, 32'h0, 32'h0);
            n_vec++;
            if (instr_valid !== 1'b0 || imem_req !== 1'b1 || pc !== 32'((i + 1) * 4)) begin
                n_err++;
                $display("FAIL seq_fetch%0d: valid=%b req=%b pc=%h required 0/1/%h",
                         i, instr_valid, imem_req, pc, 32'((i + 1) * 4));
            end
        end
    endtask

    task automatic test_wait_states();
        int req_cycles = 0;
        int pulses = 0;
        imem_rdata = ADDI;
        imem_ack   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (imem_req === 1'b1 && imem_addr === 32'h8) req_cycles++;
            if (instr_valid === 1'b1) pulses++;
            step();
        end
        if (imem_req === 1'b1 && imem_addr === 32'h8) req_cycles++;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (instr_valid === 1'b1) pulses++;
            step();
        end
        n_vec++;
        if (req_cycles !== 4) begin
            n_err++;
            $display("FAIL wait_req_cycles: got %0d required 4", req_cycles);
        end
        n_vec++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL wait_valid_pulses: got %0d required 1", pulses);
        end
        n_vec++;
        if (pc !== 32'hC) begin
            n_err++;
            $display("FAIL wait_next_pc: pc=%h required 0000000c", pc);
        end
    endtask

    task automatic test_branches();
        do_fetch(ADDI, 0);
        exec_step(0, 0, 0, 0, 0, 32'h0, 32'h0);               // pc 12 -> 16
        do_fetch(32'h0000_0063, 0);                           // BEQ
        n_vec++;
        if (op !== 7'd3 || pc !== 32'h10) begin
            n_err++;
            $display("FAIL beq_decode: op=%0d pc=%h required 3/00000010", op, pc);
        end
        exec_step(0, 0, 1, 1, 0, -32'sd8, 32'h0);
        n_vec++;
        if (pc !== 32'h8) begin
            n_err++;
            $display("FAIL beq_taken: pc=%h required 00000008", pc);
        end
        do_fetch(ADDI, 0); exec_step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        do_fetch(ADDI, 0); exec_step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        do_fetch(32'h0000_0063, 0);
        exec_step(0, 0, 1, 0, 0, -32'sd8, 32'h0);
        n_vec++;
        if (pc !== 32'h14) begin
            n_err++;
            $display("FAIL beq_not_taken: pc=%h required 00000014", pc);
        end
        do_fetch(32'h0000_1063, 0);                           // BNE, zero=0
        exec_step(0, 0, 1, 0, 0, -32'sd4, 32'h0);
        n_vec++;
        if (pc !== 32'h10) begin
            n_err++;
            $display("FAIL bne_taken: pc=%h required 00000010", pc);
        end
        do_fetch(32'h0000_4063, 0);                           // BLT, neg=1
        exec_step(0, 0, 1, 0, 1, 32'd12, 32'h0);
        n_vec++;
        if (pc !== 32'h1C) begin
            n_err++;
            $display("FAIL blt_taken: pc=%h required 0000001c", pc);
        end
        do_fetch(32'h0000_5063, 0);                           // BGE with neg=1: not taken
        exec_step(0, 0, 1, 0, 1, 32'd64, 32'h0);
        n_vec++;
        if (pc !== 32'h20) begin
            n_err++;
            $display("FAIL bge_not_taken: pc=%h required 00000020", pc);
        end
        do_fetch(32'h0000_2063, 0);                           // func3 010: never taken
        exec_step(0, 0, 1, 1, 1, 32'd64, 32'h0);
        n_vec++;
        if (pc !== 32'h24) begin
            n_err++;
            $display("FAIL br_f3_010: pc=%h required 00000024", pc);
        end
    endtask

    task automatic test_decode_table();
        logic [31:0] words [4] = '{32'h0000_0033, 32'h0000_2023, 32'h0000_00B7, 32'h0000_2003};
        logic [6:0]  ops   [4] = '{7'd0, 7'd2, 7'd4, 7'd1};
        logic [2:0]  f3s   [4] = '{3'b000, 3'b010, 3'b000, 3'b110};
        for (int i = 0; i < 4; i++) begin
            do_fetch(words[i] | 32'h4000_0000, 0);
            n_vec++;
            if (op !== ops[i] || func3 !== f3s[i] || func7 !== 7'h20) begin
                n_err++;
                $display("FAIL decode%0d: op=%0d f3=%b f7=%h required %0d/%b/20",
                         i, op, func3, func7, ops[i], f3s[i]);
            end
            exec_step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        end
        n_vec++;
        if (pc !== 32'h34) begin
            n_err++;
            $display("FAIL decode_pc: pc=%h required 00000034", pc);
        end
    endtask

    task automatic test_jumps();
        do_fetch(32'h0000_0063, 0);
        exec_step(0, 0, 1, 1, 0, 32'hC, 32'h0);               // 0x34 -> 0x40
        do_fetch(32'h0000_006F, 0);                           // JAL
        n_vec++;
        if (op !== 7'd5 || pc_plus4 !== 32'h44 || pc !== 32'h40) begin
            n_err++;
            $display("FAIL jal_exec: op=%0d pc_plus4=%h pc=%h required 5/00000044/00000040",
                     op, pc_plus4, pc);
        end
        exec_step(1, 0, 0, 0, 0, 32'h100, 32'h0);
        n_vec++;
        if (pc !== 32'h140) begin
            n_err++;
            $display("FAIL jal_target: pc=%h required 00000140", pc);
        end
        do_fetch(32'h0000_0067, 0);                           // JALR, raw func3 000
        n_vec++;
        if (op !== 7'd1 || func3 !== 3'b111) begin
            n_err++;
            $display("FAIL jalr_decode: op=%0d f3=%b required 1/111", op, func3);
        end
        exec_step(0, 1, 0, 0, 0, 32'h0, 32'h203);
`ifdef FETCH_MISALIGN_TRAP_EN
        n_vec++;
        if (halted !== 1'b1 || trap_cause !== 2'b10 || pc !== 32'h140 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL jalr_misalign: halted=%b trap=%b pc=%h req=%b required 1/10/00000140/0",
                     halted, trap_cause, pc, imem_req);
        end
`else
        n_vec++;
        if (pc !== 32'h200 || halted !== 1'b0 || trap_cause !== 2'b00) begin
            n_err++;
            $display("FAIL jalr_target: pc=%h halted=%b trap=%b required 00000200/0/00",
                     pc, halted, trap_cause);
        end
`endif
    endtask

    task automatic test_wrap();
        hold_reset();
        release_reset();
        do_fetch(32'h0000_006F, 0);
        exec_step(1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
        do_fetch(ADDI, 0);
        n_vec++;
        if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_exec: pc=%h pc_plus4=%h required fffffffc/00000000", pc, pc_plus4);
        end
        exec_step(0, 0, 0, 0, 0, 32'h0, 32'h0);
        n_vec++;
        if (pc !== 32'h0 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_pc: pc=%h req=%b required 00000000/1", pc, imem_req);
        end
    endtask

    task automatic test_illegal();
        int pulses = 0;
        do_fetch(32'h0000_0063, 0);
        exec_step(0, 0, 1, 1, 0, 32'h20, 32'h0);              // 0 -> 0x20
        do_fetch(32'hFFFF_FFFF, 0);
        n_vec++;
        if (halted !== 1'b1 || trap_cause !== 2'b01 || pc !== 32'h20) begin
            n_err++;
            $display("FAIL illegal_halt: halted=%b trap=%b pc=%h required 1/01/00000020",
                     halted, trap_cause, pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = ADDI;
        for (int i = 0; i < 5; i++) begin
            if (instr_valid === 1'b1 || imem_req === 1'b1) pulses++;
            step();
        end
        imem_ack = 1'b0;
        n_vec++;
        if (pulses !== 0 || halted !== 1'b1 || pc !== 32'h20 || instr !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL halt_absorb: activity=%0d halted=%b pc=%h instr=%h required 0/1/00000020/ffffffff",
                     pulses, halted, pc, instr);
        end
        hold_reset();
        release_reset();
        n_vec++;
        if (halted !== 1'b0 || trap_cause !== 2'b00 || pc !== 32'h0 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL halt_restart: halted=%b trap=%b pc=%h req=%b required 0/00/00000000/1",
                     halted, trap_cause, pc, imem_req);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_fetch(32'h0000_0063, 0);
        exec_step(0, 0, 1, 1, 0, 32'h30, 32'h0);              // 0 -> 0x30
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin
            n_err++;
            $display("FAIL midreset_pre: req=%b addr=%h required 1/00000030", imem_req, imem_addr);
        end
        imem_rdata = 32'h0000_0033;
        imem_ack   = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0000_0013 || op !== 7'd1 ||
            instr_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_async: req=%b pc=%h instr=%h op=%0d valid=%b required 0/00000000/00000013/1/0",
                     imem_req, pc, instr, op, instr_valid);
        end
        step();
        n_vec++;
        if (instr !== 32'h0000_0013 || pc !== 32'h0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_ack_ignored: instr=%h pc=%h req=%b required 00000013/00000000/0",
                     instr, pc, imem_req);
        end
        imem_ack = 1'b0;
        release_reset();
        n_vec++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h0000_0013) begin
            n_err++;
            $display("FAIL midreset_restart: req=%b addr=%h instr=%h required 1/00000000/00000013",
                     imem_req, imem_addr, instr);
        end
    endtask

    initial begin
        rst        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        clear_ctrl();
        repeat (2) @(posedge clk);
        test_reset();
        test_sequential();
        test_wait_states();
        test_branches();
        test_decode_table();
        test_jumps();
        test_wrap();
        test_illegal();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
